codec_fault_injector: RTL and testbench

//  Upstream stimulus stage for the 16->24 bit codec power/robustness evaluation.

---
 rtl/codec_fault_injector.sv | 146 ++++++++++++++
 tb/tb_codec_fault_injector.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_fault_injector.sv
// Stimulus generator for the 16->24 bit codec evaluation: emits bursts of
// pseudo-random data words with a matching 24-bit bit-flip pattern per word.
module codec_fault_injector #(
  parameter logic [15:0] DATA_SEED = 16'hACE1,
  parameter logic [15:0] POS_SEED  = 16'h1D2B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [15:0] data_out,
  output logic [23:0] flip_out
);

  localparam logic [15:0] DATA_INIT = (DATA_SEED == 16'h0000) ? 16'h0001 : DATA_SEED;
  localparam logic [15:0] POS_INIT  = (POS_SEED  == 16'h0000) ? 16'h0001 : POS_SEED;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] data_lfsr, data_lfsr_n;
  logic [15:0] pos_lfsr, pos_lfsr_n;
  logic [15:0] rem, rem_n;
  logic [4:0]  widx, widx_n;
  logic [1:0]  mode_q, mode_n;
  logic        busy_n, done_n, valid_n;
  logic [15:0] data_out_n;
  logic [23:0] flip_out_n;
  logic        emit;
  logic [1:0]  emit_mode;
  logic [4:0]  emit_widx;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [4:0] fold_pos(input logic [4:0] r);
    return (r >= 5'd24) ? r - 5'd24 : r;
  endfunction

  function automatic logic [23:0] flip_pattern(input logic [1:0] m, input logic [4:0] w,
                                               input logic [15:0] p);
    logic [4:0]  a, b;
    logic [23:0] one;
    one = 24'd1;
    a   = fold_pos(p[4:0]);
    b   = fold_pos(p[9:5]);
    // Colliding second position is nudged to the next bit so weight stays 2
    if (b == a) b = (a == 5'd23) ? 5'd0 : a + 5'd1;
    case (m)
      2'd1:    return one << w;
      2'd2:    return one << a;
      2'd3:    return (one << a) | (one << b);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_n     = state;
    data_lfsr_n = data_lfsr;
    pos_lfsr_n  = pos_lfsr;
    rem_n       = rem;
    widx_n      = widx;
    mode_n      = mode_q;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    valid_n     = 1'b0;
    data_out_n  = data_out;
    flip_out_n  = flip_out;
    emit        = 1'b0;
    emit_mode   = mode_q;
    emit_widx   = widx;

    case (state)
      IDLE: begin
        if (start) begin
          if (count != 16'd0) begin
            mode_n    = mode;
            rem_n     = count - 16'd1;
            emit      = 1'b1;
            emit_mode = mode;
            emit_widx = 5'd0;
            state_n   = RUN;
          end else begin
            done_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (rem == 16'd0) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          rem_n = rem - 16'd1;
          emit  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (emit) begin
      valid_n     = 1'b1;
      busy_n      = 1'b1;
      data_out_n  = data_lfsr;
      flip_out_n  = flip_pattern(emit_mode, emit_widx, pos_lfsr);
      data_lfsr_n = lfsr_step(data_lfsr);
      pos_lfsr_n  = lfsr_step(pos_lfsr);
      widx_n      = (emit_widx == 5'd23) ? 5'd0 : emit_widx + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_lfsr <= DATA_INIT;
      pos_lfsr  <= POS_INIT;
      rem       <= '0;
      widx      <= '0;
      mode_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      data_out  <= '0;
      flip_out  <= '0;
    end else begin
      state     <= state_n;
      data_lfsr <= data_lfsr_n;
      pos_lfsr  <= pos_lfsr_n;
      rem       <= rem_n;
      widx      <= widx_n;
      mode_q    <= mode_n;
      busy      <= busy_n;
      done      <= done_n;
      valid     <= valid_n;
      data_out  <= data_out_n;
      flip_out  <= flip_out_n;
    end
  end

endmodule

// File: tb/tb_codec_fault_injector.sv
// Bench for codec_fault_injector: burst table plus hand-written corner cases,
// with a scoreboard queue fed by an independent LFSR/flip model.
module tb_codec_fault_injector;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] count;
  logic        busy, done, valid;
  logic [15:0] data_out;
  logic [23:0] flip_out;

  codec_fault_injector #(.DATA_SEED(16'hACE1), .POS_SEED(16'h1D2B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .count(count),
    .busy(busy), .done(done), .valid(valid), .data_out(data_out), .flip_out(flip_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [23:0] flip;
    int          pc;
  } item_t;

  typedef struct {
    logic [1:0]  mode;
    int          count;
    bit          repulse;
    int          exp_words;
    int          exp_dones;
    bit          chk_flip;
    logic [23:0] first_flip;
  } vec_t;

  item_t       sb[$];
  int          compared = 0;
  int          mismatched = 0;
  int          words_seen = 0;
  int          dones_seen = 0;
  logic [15:0] cap_data[3];
  logic [23:0] cap_flip0;
  logic [15:0] m_data, m_pos;

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] t;
    t = {1'b0, s[15:1]};
    if (s[0] == 1'b1) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic int m_fold(input int r);
    if (r >= 24) return r - 24;
    return r;
  endfunction

  function automatic logic [23:0] m_flip(input logic [1:0] md, input int k, input logic [15:0] p);
    int a, b;
    logic [23:0] f;
    f = '0;
    a = m_fold(int'(p) % 32);
    b = m_fold((int'(p) / 32) % 32);
    if (b == a) b = (a == 23) ? 0 : a + 1;
    if (md == 2'd1) f[k % 24] = 1'b1;
    if (md == 2'd2) f[a] = 1'b1;
    if (md == 2'd3) begin f[a] = 1'b1; f[b] = 1'b1; end
    return f;
  endfunction

  function automatic int popc(input logic [23:0] v);
    int n = 0;
    for (int i = 0; i < 24; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 16'hACE1;
    m_pos  = 16'h1D2B;
    sb.delete();
  endtask

  task automatic push_burst(input logic [1:0] md, input int n);
    item_t it;
    for (int k = 0; k < n; k++) begin
      it.data = m_data;
      it.flip = m_flip(md, k, m_pos);
      it.pc   = (md == 2'd0) ? 0 : (md == 2'd3) ? 2 : 1;
      sb.push_back(it);
      m_data = m_step(m_data);
      m_pos  = m_step(m_pos);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) dones_seen++;
      compared++;
      if (busy !== valid) begin
        mismatched++;
        $display("FAIL busy_vs_valid: busy=%0b valid=%0b", busy, valid);
      end
      if (valid) begin
        if (words_seen < 3) cap_data[words_seen] = data_out;
        if (words_seen == 0) cap_flip0 = flip_out;
        words_seen++;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL extra_word: data=%h flip=%h with empty scoreboard", data_out, flip_out);
        end else begin
          item_t e;
          e = sb.pop_front();
          if (data_out !== e.data || flip_out !== e.flip) begin
            mismatched++;
            $display("FAIL word: data=%h flip=%h expected data=%h flip=%h",
                     data_out, flip_out, e.data, e.flip);
          end
          compared++;
          if (popc(flip_out) != e.pc) begin
            mismatched++;
            $display("FAIL popcount: got %0d expected %0d", popc(flip_out), e.pc);
          end
        end
      end
    end
  end

  task automatic run_burst(input logic [1:0] md, input int n, input bit repulse,
                           output int got_words, output int got_dones);
    push_burst(md, n);
    words_seen = 0;
    dones_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; count = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (repulse) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; mode = 2'd3; count = 16'd5;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int c = 0; c < n + 20 && dones_seen == 0; c++) @(posedge clk);
    if (dones_seen == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: no done within %0d cycles", n + 20);
    end
    repeat (4) @(posedge clk);
    got_words = words_seen;
    got_dones = dones_seen;
  endtask

  vec_t vecs[5];

  initial begin
    int gw, gd;
    vecs[0] = '{mode: 2'd0, count: 3,    repulse: 1'b0, exp_words: 3,    exp_dones: 1, chk_flip: 1'b1, first_flip: 24'h000000};
    vecs[1] = '{mode: 2'd1, count: 26,   repulse: 1'b0, exp_words: 26,   exp_dones: 1, chk_flip: 1'b1, first_flip: 24'h000001};
    vecs[2] = '{mode: 2'd2, count: 20,   repulse: 1'b0, exp_words: 20,   exp_dones: 1, chk_flip: 1'b0, first_flip: 24'h000000};
    vecs[3] = '{mode: 2'd3, count: 1000, repulse: 1'b0, exp_words: 1000, exp_dones: 1, chk_flip: 1'b0, first_flip: 24'h000000};
    vecs[4] = '{mode: 2'd1, count: 10,   repulse: 1'b1, exp_words: 10,   exp_dones: 1, chk_flip: 1'b1, first_flip: 24'h000001};

    start = 1'b0; mode = 2'd0; count = 16'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, valid, data_out, flip_out}, 43'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, done, valid}, 3'd0);

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i].mode, vecs[i].count, vecs[i].repulse, gw, gd);
      check($sformatf("vec%0d_words", i), gw, vecs[i].exp_words);
      check($sformatf("vec%0d_dones", i), gd, vecs[i].exp_dones);
      check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
      if (vecs[i].chk_flip) check($sformatf("vec%0d_first_flip", i), cap_flip0, vecs[i].first_flip);
      if (i == 0) begin
        check("first_data0", cap_data[0], 16'hACE1);
        check("first_data1", cap_data[1], 16'hE270);
        check("first_data2", cap_data[2], 16'h7138);
      end
    end

    // count==0: done on the next cycle, no valid/busy
    words_seen = 0; dones_seen = 0;
    @(posedge clk); #1; start = 1'b1; count = 16'd0; mode = 2'd2;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1'b1);
    check("zero_valid_busy", {valid, busy}, 2'd0);
    @(negedge clk);
    check("zero_done_drop", done, 1'b0);
    repeat (3) @(posedge clk);
    check("zero_words", words_seen, 0);
    check("zero_dones", dones_seen, 1);

    // reset during word 4 of an 8-word burst
    push_burst(2'd0, 8);
    words_seen = 0; dones_seen = 0;
    @(posedge clk); #1; start = 1'b1; mode = 2'd0; count = 16'd8;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 20 && words_seen < 4; c++) @(negedge clk);
    check("midreset_reached_word4", words_seen, 4);
    #2; rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, valid, data_out, flip_out}, 43'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check("midreset_no_done", dones_seen, 0);
    run_burst(2'd0, 3, 1'b0, gw, gd);
    check("postreset_words", gw, 3);
    check("postreset_first", cap_data[0], 16'hACE1);
    check("postreset_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
